// File: rtl/eeprom_txn_sequencer.sv
// rtl/eeprom_txn_sequencer.sv - two-requester round-robin transaction sequencer for the I2C EEPROM controller
module eeprom_txn_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h50,
    parameter logic [2:0]  CLK_SEL        = 3'd6,
    parameter logic [19:0] WR_CYCLES      = 20'd500000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    input  logic        i_req0_rw,
    input  logic [15:0] i_req0_addr,
    input  logic [31:0] i_req0_wdata,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic        i_req1_rw,
    input  logic [15:0] i_req1_addr,
    input  logic [31:0] i_req1_wdata,
    output logic        o_req1_ready,
    output logic        o_rsp_valid,
    output logic        o_rsp_id,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err,
    output logic        o_busy,
    output logic [6:0]  o_dev_addr,
    output logic [31:0] o_ctrl,
    output logic [15:0] o_reg_addr,
    output logic [31:0] o_w_data,
    output logic        o_ctrl_rst_n,
    input  logic [31:0] i_status,
    input  logic [31:0] i_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DONE,
        S_WR_WAIT,
        S_RECOVER
    } state_t;

    localparam logic [23:0] TMO_LAST   = TIMEOUT_CYCLES - 24'd1;
    localparam logic [23:0] WR_LAST    = {4'b0, WR_CYCLES - 20'd1};
    localparam logic [23:0] RST_LAST   = 24'd15;
    localparam logic [1:0]  ERR_OK     = 2'd0;
    localparam logic [1:0]  ERR_NACK   = 2'd1;
    localparam logic [1:0]  ERR_TMO    = 2'd2;

    state_t      state_q,      state_d;
    logic        rdy_meta_q,   rdy_meta_d;
    logic        rdy_s_q,      rdy_s_d;
    logic        fin_meta_q,   fin_meta_d;
    logic        fin_s_q,      fin_s_d;
    logic        last_q,       last_d;
    logic        id_q,         id_d;
    logic        rw_q,         rw_d;
    logic        en_q,         en_d;
    logic [15:0] reg_addr_q,   reg_addr_d;
    logic [31:0] w_data_q,     w_data_d;
    logic        fin_seen_q,   fin_seen_d;
    logic [23:0] cnt_q,        cnt_d;
    logic        rsp_valid_q,  rsp_valid_d;
    logic        rsp_id_q,     rsp_id_d;
    logic [31:0] rsp_rdata_q,  rsp_rdata_d;
    logic [1:0]  rsp_err_q,    rsp_err_d;
    logic        ctrl_rst_n_q, ctrl_rst_n_d;

    logic        grant_any;
    logic        winner;
    logic        unused_status;

    assign unused_status = &{1'b0, i_status[31:2]};

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        winner = i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            winner = ~last_q;
        end
    end

    assign grant_any    = (state_q == S_IDLE) && rdy_s_q && (i_req0_valid || i_req1_valid);
    assign o_req0_ready = grant_any && !winner;
    assign o_req1_ready = grant_any && winner;

    // Next-state and registered-output computation for the whole sequencer.
    always_comb begin
        state_d      = state_q;
        rdy_meta_d   = i_status[0];
        rdy_s_d      = rdy_meta_q;
        fin_meta_d   = i_status[1];
        fin_s_d      = fin_meta_q;
        last_d       = last_q;
        id_d         = id_q;
        rw_d         = rw_q;
        en_d         = en_q;
        reg_addr_d   = reg_addr_q;
        w_data_d     = w_data_q;
        fin_seen_d   = fin_seen_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        ctrl_rst_n_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    id_d       = winner;
                    last_d     = winner;
                    rw_d       = winner ? i_req1_rw    : i_req0_rw;
                    reg_addr_d = winner ? i_req1_addr  : i_req0_addr;
                    w_data_d   = winner ? i_req1_wdata : i_req0_wdata;
                    fin_seen_d = 1'b0;
                    en_d       = 1'b1;
                    cnt_d      = 24'd0;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH, S_BUSY: begin
                cnt_d = cnt_q + 24'd1;
                if (state_q == S_BUSY && fin_s_q) begin
                    fin_seen_d = 1'b1;
                end
                if (state_q == S_BUSY && rdy_s_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    if (fin_seen_q || fin_s_q) begin
                        rsp_err_d   = ERR_OK;
                        rsp_rdata_d = rw_q ? i_rd_data : 32'd0;
                    end else begin
                        rsp_err_d   = ERR_NACK;
                        rsp_rdata_d = 32'd0;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    // Controller hung: drop enable, report, and reset it.
                    en_d         = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_err_d    = ERR_TMO;
                    rsp_rdata_d  = 32'd0;
                    ctrl_rst_n_d = 1'b0;
                    cnt_d        = 24'd0;
                    state_d      = S_RECOVER;
                end else if (state_q == S_LAUNCH && !rdy_s_q) begin
                    // Controller has taken the command; release enable so it
                    // does not re-trigger when it returns to idle.
                    en_d    = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (rsp_err_q == ERR_OK && !rw_q) begin
                    cnt_d   = 24'd0;
                    state_d = S_WR_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_WAIT: begin
                if (cnt_q == WR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_RECOVER: begin
                if (!ctrl_rst_n_q) begin
                    if (cnt_q == RST_LAST) begin
                        ctrl_rst_n_d = 1'b1;
                    end else begin
                        ctrl_rst_n_d = 1'b0;
                        cnt_d        = cnt_q + 24'd1;
                    end
                end else if (rdy_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous clear; controller reset follows i_rst_n.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            rdy_meta_q   <= 1'b0;
            rdy_s_q      <= 1'b0;
            fin_meta_q   <= 1'b0;
            fin_s_q      <= 1'b0;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            rw_q         <= 1'b0;
            en_q         <= 1'b0;
            reg_addr_q   <= 16'd0;
            w_data_q     <= 32'd0;
            fin_seen_q   <= 1'b0;
            cnt_q        <= 24'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_err_q    <= 2'd0;
            ctrl_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_meta_q   <= rdy_meta_d;
            rdy_s_q      <= rdy_s_d;
            fin_meta_q   <= fin_meta_d;
            fin_s_q      <= fin_s_d;
            last_q       <= last_d;
            id_q         <= id_d;
            rw_q         <= rw_d;
            en_q         <= en_d;
            reg_addr_q   <= reg_addr_d;
            w_data_q     <= w_data_d;
            fin_seen_q   <= fin_seen_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            ctrl_rst_n_q <= ctrl_rst_n_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_dev_addr   = DEV_ADDR;
    assign o_ctrl       = {25'd0, CLK_SEL, 2'b00, rw_q, en_q};
    assign o_reg_addr   = reg_addr_q;
    assign o_w_data     = w_data_q;
    assign o_ctrl_rst_n = ctrl_rst_n_q;

endmodule
